cs_rx_frame_fifo: RTL and testbench
===================================

# cs_rx_frame_fifo

Store-and-forward frame FIFO for the CS receive path. It sits directly downstream of the pre-MAC switch's CS output (m_to_cs_axis_*) and upstream of the CS eth_axis_rx. The upstream GMII-fed path cannot be back-pressured, so this block absorbs the whole frame before releasing it. It discards frames flagged bad (tuser on tlast) or frames that overflow the buffer, so CS only ever sees complete, good frames.

## Interface
- ADDR_WIDTH, 11: log2 of buffer depth in bytes (DEPTH = 2^ADDR_WIDTH).
- CNT_WIDTH, 16: width of the saturating statistics counters.

- clk  in  1: stream clock (125 MHz domain).
- reset_n  in  1: one clock; reset is asynchronous and active-low.
- s_axis_tdata  in  8: input byte.
- s_axis_tvalid  in  1: input beat valid.
- s_axis_tready  out  1: constant 1 after reset; the block never back-pressures.
- s_axis_tlast  in  1: last byte of frame.
- s_axis_tuser  in  1: bad-frame flag, sampled only on the tlast beat.
- m_axis_tdata  out  8: output byte.
- m_axis_tvalid  out  1: output beat valid.
- m_axis_tready  in  1: downstream ready.
- m_axis_tlast  out  1: last byte of frame.
- m_axis_tuser  out  1: constant 0; bad frames never leave the block.
- fifo_level  out  ADDR_WIDTH+1: bytes written and not yet read, committed or not.
- overflow  out  1: one-cycle pulse when a frame is dropped for overflow.
- bad_frame  out  1: one-cycle pulse when a frame is dropped for tuser.
- stat_good_frames  out  CNT_WIDTH: count of committed frames.
- stat_bad_frames  out  CNT_WIDTH: count of tuser drops.
- stat_ovf_frames  out  CNT_WIDTH: count of overflow drops.

## Operation
- Storage: DEPTH x 9-bit RAM holding {tlast, tdata}.
- Pointers: wr_ptr, commit_ptr and rd_ptr, each ADDR_WIDTH+1 bits with a wrap bit.
  - Full: wr_ptr − rd_ptr == DEPTH.
  - Frame available: rd_ptr != commit_ptr.
- Write FSM states:
  - IDLE to WRITE: on any accepted beat that is not tlast. A single-beat frame (tlast in IDLE) is handled in place using the tlast rules below.
  - WRITE: each beat is written at wr_ptr, then wr_ptr increments.
  - WRITE to DROP: a beat arrives while full. That beat is discarded.
  - DROP: all beats are discarded until tlast.
- tlast beat, WRITE/IDLE with tuser=0 and not full:
  - Write the beat.
  - commit_ptr ← wr_ptr+1.
  - Increment stat_good_frames.
  - Go to IDLE.
- tlast beat, WRITE/IDLE with tuser=1:
  - wr_ptr ← commit_ptr (rewind).
  - Pulse bad_frame and increment stat_bad_frames.
  - Go to IDLE.
- tlast beat in DROP, or a tlast beat that arrives while full:
  - wr_ptr ← commit_ptr.
  - Pulse overflow and increment stat_ovf_frames.
  - Go to IDLE.
  - Overflow takes precedence over tuser.
- Read side, single output register:
  - Load RAM[rd_ptr] and increment rd_ptr when a frame is available and the output register is either empty or being consumed (m_axis_tvalid & m_axis_tready).
  - Otherwise clear m_axis_tvalid on consume.
- A frame larger than DEPTH always overflows and is dropped. It never deadlocks.
- Counters saturate at 2^CNT_WIDTH−1.
- Reset values:
  - All pointers 0; write FSM in IDLE.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Pulses 0, counters 0, fifo_level 0.
- Reset mid-frame: the partial frame is lost and the pointers return to empty. The remaining upstream bytes are treated as a new frame; the shared upstream reset prevents this in practice.

## Timing
- Write: one byte per cycle, with no bubbles required between frames (tlast followed by a new byte on the next cycle is legal).
- Commit latency:
  - tlast accepted in cycle N.
  - commit_ptr is visible in N+1.
  - Earliest m_axis_tvalid for that frame is N+2.
- Read: one byte per cycle while m_axis_tready=1. An empty-to-valid transition costs one cycle.
- Simultaneous read and write in one cycle: legal.
  - Full is evaluated with the pre-edge rd_ptr, so a byte freed in the same cycle is not usable until the next cycle.
- Simultaneous commit and output load: the load uses the pre-edge commit_ptr.
- overflow and bad_frame pulse in cycle N+1 for a tlast accepted in cycle N.

## Configuration
- CS_RX_FIFO_STATS_EN:
  - Defined: the three stat_* counters are implemented as described.
  - Undefined: stat_* are tied to 0 and no counter logic is built. The overflow and bad_frame pulses remain.

## Test plan
- Single good 64-byte frame (bytes 0x00..0x3F, tuser=0), m_axis_tready=1 → identical 64 bytes out, tlast on 0x3F, first valid 2 cycles after input tlast; stat_good_frames=1.
- 60-byte frame with tuser=1 on tlast → no output beats, bad_frame pulses once, stat_bad_frames=1, fifo_level returns to 0.
- ADDR_WIDTH=6, m_axis_tready=0, 100-byte frame → dropped, overflow pulses, stat_ovf_frames=1. A following 40-byte good frame is delivered intact once tready=1.
- Back-to-back 1-byte frames 0xA5, 0x5A (tlast each beat) → two single-beat outputs, each with tlast=1; stat_good_frames=2.
- Random m_axis_tready (50%) over 200 frames of 60–1514 bytes, ADDR_WIDTH=11 → byte-exact order preserved. Every frame either delivered or counted as an overflow drop; none partial.
- Assert reset_n low mid-frame (byte 30 of 64) → all outputs at reset values asynchronously. The next complete frame after release is delivered correctly.

Source files
------------

// File: rtl/cs_rx_frame_fifo.sv
// rtl/cs_rx_frame_fifo.sv - store-and-forward receive frame FIFO that drops bad and overflowed frames
// Optional statistics counters are built when CS_RX_FIFO_STATS_EN is defined.
module cs_rx_frame_fifo #(
   parameter int ADDR_WIDTH = 11,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [ADDR_WIDTH:0]   fifo_level,
   output logic                  overflow,
   output logic                  bad_frame,
   output logic [CNT_WIDTH-1:0]  stat_good_frames,
   output logic [CNT_WIDTH-1:0]  stat_bad_frames,
   output logic [CNT_WIDTH-1:0]  stat_ovf_frames
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_PTR = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_DROP
   } wr_state_t;

   wr_state_t             state, state_nxt;
   logic [ADDR_WIDTH:0]   wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH:0]   commit_ptr, commit_ptr_nxt;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  mem_we;
   logic                  bad_nxt;
   logic                  ovf_nxt;
   logic                  full;
   logic                  frame_avail;
   logic                  rd_load;
   logic [8:0]            rd_word;
   logic [8:0]            mem [DEPTH];

   assign fifo_level   = wr_ptr - rd_ptr;
   assign full         = (fifo_level == DEPTH_PTR);
   assign frame_avail  = (rd_ptr != commit_ptr);
   assign rd_load      = frame_avail && (!m_axis_tvalid || m_axis_tready);
   assign rd_word      = mem[rd_ptr[ADDR_WIDTH-1:0]];
   assign m_axis_tuser = 1'b0;

   // Once a frame cannot fit, every remaining beat is discarded and the frame is rewound at tlast;
   // overflow wins over the tuser flag.
   always_comb begin
      state_nxt      = state;
      wr_ptr_nxt     = wr_ptr;
      commit_ptr_nxt = commit_ptr;
      mem_we         = 1'b0;
      bad_nxt        = 1'b0;
      ovf_nxt        = 1'b0;
      if (s_axis_tvalid && s_axis_tready) begin
         if (state == ST_DROP || full) begin
            if (s_axis_tlast) begin
               wr_ptr_nxt = commit_ptr;
               ovf_nxt    = 1'b1;
               state_nxt  = ST_IDLE;
            end else begin
               state_nxt  = ST_DROP;
            end
         end else if (s_axis_tlast) begin
            if (s_axis_tuser) begin
               wr_ptr_nxt = commit_ptr;
               bad_nxt    = 1'b1;
            end else begin
               mem_we         = 1'b1;
               wr_ptr_nxt     = wr_ptr + 1'b1;
               commit_ptr_nxt = wr_ptr + 1'b1;
            end
            state_nxt = ST_IDLE;
         end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            state_nxt  = ST_WRITE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         wr_ptr        <= '0;
         commit_ptr    <= '0;
         s_axis_tready <= 1'b0;
         overflow      <= 1'b0;
         bad_frame     <= 1'b0;
      end else begin
         state         <= state_nxt;
         wr_ptr        <= wr_ptr_nxt;
         commit_ptr    <= commit_ptr_nxt;
         s_axis_tready <= 1'b1;
         overflow      <= ovf_nxt;
         bad_frame     <= bad_nxt;
      end
   end

   // Output register loads from the pre-edge commit_ptr, so a commit is readable one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr        <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (rd_load) begin
         rd_ptr        <= rd_ptr + 1'b1;
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= rd_word[7:0];
         m_axis_tlast  <= rd_word[8];
      end else if (m_axis_tvalid && m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

`ifdef CS_RX_FIFO_STATS_EN
   logic [CNT_WIDTH-1:0] good_cnt, bad_cnt, ovf_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
         ovf_cnt  <= '0;
      end else begin
         if (commit_ptr_nxt != commit_ptr && good_cnt != '1) begin
            good_cnt <= good_cnt + 1'b1;
         end
         if (bad_nxt && bad_cnt != '1) begin
            bad_cnt <= bad_cnt + 1'b1;
         end
         if (ovf_nxt && ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + 1'b1;
         end
      end
   end

   assign stat_good_frames = good_cnt;
   assign stat_bad_frames  = bad_cnt;
   assign stat_ovf_frames  = ovf_cnt;
`else
   assign stat_good_frames = '0;
   assign stat_bad_frames  = '0;
   assign stat_ovf_frames  = '0;
`endif

endmodule

// File: tb/tb_cs_rx_frame_fifo.sv
// tb/tb_cs_rx_frame_fifo.sv - self-checking bench for cs_rx_frame_fifo (64-byte buffer)
module tb_cs_rx_frame_fifo;

   localparam int AW    = 6;
   localparam int CW    = 16;
   localparam int NRAND = 200;

   typedef struct {
      int         len;
      logic [7:0] base;
      logic       tuser;
      logic       hold;
      int         kind;   // 0 delivered, 1 bad drop, 2 overflow drop
      int         lat;    // 0 = latency not checked
   } vec_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tuser = 1'b0;
   logic          s_tready;
   logic [7:0]    m_tdata;
   logic          m_tvalid;
   logic          m_tready;
   logic          m_tlast;
   logic          m_tuser;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic          bad_frame;
   logic [CW-1:0] stat_good, stat_bad, stat_ovf;

   logic ready_cmd = 1'b1;
   logic rand_ready = 1'b0;
   logic rnd_bit = 1'b1;
   assign m_tready = rand_ready ? rnd_bit : ready_cmd;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int in_tlast_cyc = 0;
   int pulse_cyc = 0;
   int ovf_cnt = 0;
   int bad_cnt = 0;
   int tuser_seen = 0;
   int exp_good = 0, exp_bad = 0, exp_ovf = 0;
   logic [8:0] out_q[$];
   int         out_cyc[$];
   int         lens[NRAND];
   vec_t       vecs[9];

   cs_rx_frame_fifo #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
      .fifo_level(fifo_level), .overflow(overflow), .bad_frame(bad_frame),
      .stat_good_frames(stat_good), .stat_bad_frames(stat_bad), .stat_ovf_frames(stat_ovf)
   );

   always #4 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rnd_bit <= 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (m_tvalid && m_tready) begin
            out_q.push_back({m_tlast, m_tdata});
            out_cyc.push_back(cyc);
            if (m_tuser) tuser_seen++;
         end
         if (s_tvalid && s_tlast) in_tlast_cyc = cyc;
         if (overflow) begin ovf_cnt++; pulse_cyc = cyc; end
         if (bad_frame) begin bad_cnt++; pulse_cyc = cyc; end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int stat_exp(input int v);
`ifdef CS_RX_FIFO_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic check_stats(input string tag);
      check({tag, "_stat_good"}, int'(stat_good), stat_exp(exp_good));
      check({tag, "_stat_bad"},  int'(stat_bad),  stat_exp(exp_bad));
      check({tag, "_stat_ovf"},  int'(stat_ovf),  stat_exp(exp_ovf));
   endtask

   task automatic send_frame(input int len, input logic [7:0] base, input logic [7:0] step,
                             input logic tuser);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         s_tvalid = 1'b1;
         s_tdata  = base + 8'(i) * step;
         s_tlast  = (i == len - 1);
         s_tuser  = (i == len - 1) ? tuser : 1'b0;
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((fifo_level != 0 || m_tvalid) && n < 4000);
      check({tag, "_drain_ok"}, int'(n < 4000), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int start, b0, o0, n, bad_bytes;
      logic [8:0] exp_w;
      start = out_q.size();
      b0    = bad_cnt;
      o0    = ovf_cnt;
      ready_cmd = !v.hold;
      send_frame(v.len, v.base, 8'd1, v.tuser);
      ready_cmd = 1'b1;
      drain(tag);
      n = (v.kind == 0) ? v.len : 0;
      if (v.kind == 0) exp_good++;
      if (v.kind == 1) exp_bad++;
      if (v.kind == 2) exp_ovf++;
      check({tag, "_out_beats"}, out_q.size() - start, n);
      bad_bytes = 0;
      for (int i = 0; i < n && start + i < out_q.size(); i++) begin
         exp_w = {(i == n - 1), v.base + 8'(i)};
         if (out_q[start + i] !== exp_w) bad_bytes++;
      end
      check({tag, "_bytes_wrong"}, bad_bytes, 0);
      check({tag, "_bad_pulses"}, bad_cnt - b0, int'(v.kind == 1));
      check({tag, "_ovf_pulses"}, ovf_cnt - o0, int'(v.kind == 2));
      if (v.kind != 0) check({tag, "_pulse_delay"}, pulse_cyc - in_tlast_cyc, 1);
      if (v.lat != 0 && out_q.size() > start)
         check({tag, "_first_valid_delay"}, out_cyc[start] - in_tlast_cyc, v.lat);
      check({tag, "_level"}, int'(fifo_level), 0);
      check_stats(tag);
   endtask

   initial begin
      int start, prev, idx, delivered, rbad, id, o0, b0;
      logic [8:0] exp_w;

      vecs[0] = '{64,  8'h00, 1'b0, 1'b0, 0, 2};
      vecs[1] = '{60,  8'h10, 1'b1, 1'b0, 1, 0};
      vecs[2] = '{100, 8'h20, 1'b0, 1'b1, 2, 0};
      vecs[3] = '{40,  8'h40, 1'b0, 1'b1, 0, 0};
      vecs[4] = '{1,   8'hC3, 1'b0, 1'b0, 0, 2};
      vecs[5] = '{1,   8'h77, 1'b1, 1'b0, 1, 0};
      vecs[6] = '{65,  8'h90, 1'b0, 1'b0, 2, 0};
      vecs[7] = '{64,  8'h33, 1'b0, 1'b1, 0, 0};
      vecs[8] = '{70,  8'h05, 1'b1, 1'b0, 2, 0};

      #3;
      check("rst_m_tvalid", int'(m_tvalid), 0);
      check("rst_m_tdata",  int'(m_tdata), 0);
      check("rst_m_tlast",  int'(m_tlast), 0);
      check("rst_level",    int'(fifo_level), 0);
      check("rst_pulses",   int'({overflow, bad_frame}), 0);
      check_stats("rst");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("s_tready_after_reset", int'(s_tready), 1);

      for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("v%0d", k));

      // back-to-back single-beat frames with no idle cycle between them
      start = out_q.size();
      @(posedge clk); #1;
      s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1; s_tuser = 1'b0;
      @(posedge clk); #1;
      s_tdata = 8'h5A;
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      drain("b2b");
      exp_good += 2;
      check("b2b_beats", out_q.size() - start, 2);
      if (out_q.size() >= start + 2) begin
         check("b2b_first",  int'(out_q[start]),     int'(9'h1A5));
         check("b2b_second", int'(out_q[start + 1]), int'(9'h15A));
      end
      check_stats("b2b");

      // random frames against random downstream ready
      start = out_q.size();
      o0 = ovf_cnt;
      b0 = bad_cnt;
      rand_ready = 1'b1;
      for (int f = 0; f < NRAND; f++) begin
         lens[f] = $urandom_range(1, 48);
         send_frame(lens[f], 8'(f), 8'd3, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      rand_ready = 1'b0;
      ready_cmd  = 1'b1;
      drain("rnd");
      prev = -1; idx = start; delivered = 0; rbad = 0;
      while (idx < out_q.size()) begin
         id = int'(out_q[idx][7:0]);
         if (id <= prev || id >= NRAND) begin
            rbad++;
            break;
         end
         for (int i = 0; i < lens[id]; i++) begin
            exp_w = {(i == lens[id] - 1), 8'(id) + 8'(i) * 8'd3};
            if (idx + i >= out_q.size() || out_q[idx + i] !== exp_w) rbad++;
         end
         idx += lens[id];
         prev = id;
         delivered++;
      end
      check("rnd_frames_wrong", rbad, 0);
      check("rnd_accounted", delivered + (ovf_cnt - o0), NRAND);
      check("rnd_bad_pulses", bad_cnt - b0, 0);
      exp_good += delivered;
      exp_ovf  += ovf_cnt - o0;
      check_stats("rnd");
      check("m_tuser_seen", tuser_seen, 0);

      // reset in the middle of a frame while a committed frame is waiting
      ready_cmd = 1'b0;
      send_frame(10, 8'h80, 8'd1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_valid", int'(m_tvalid), 1);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         s_tvalid = 1'b1; s_tdata = 8'(i); s_tlast = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_m_tvalid", int'(m_tvalid), 0);
      check("mid_rst_m_tdata",  int'(m_tdata), 0);
      check("mid_rst_level",    int'(fifo_level), 0);
      check("mid_rst_stat_good", int'(stat_good), 0);
      s_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      ready_cmd = 1'b1;
      exp_good = 0; exp_bad = 0; exp_ovf = 0;
      repeat (3) @(posedge clk);
      run_vec(vecs[0], "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
